// File: rtl/level_room_engine.sv
// Room engine for one H.E.R.O. level: loadable wall table, bomb/spider/miner
// game state and a two-stage box renderer feeding the VGA mixer.
module level_room_engine #(
    parameter int NUM_WALLS   = 8,
    parameter int COORD_W     = 10,
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int CHAR_HX     = 13,
    parameter int CHAR_HY     = 28,
    parameter int EN_HX       = 7,
    parameter int EN_HY       = 5,
    parameter int EN_X        = 250,
    parameter int EN_Y_MIN    = 140,
    parameter int EN_Y_MAX    = 230,
    parameter int EN_STEP     = 2,
    parameter int MIN_X       = 550,
    parameter int MIN_Y       = 233,
    parameter int MIN_HX      = 15,
    parameter int MIN_HY      = 17,
    parameter int BOMB_H      = 10,
    parameter int BLAST_R     = 40,
    parameter int FUSE_FRAMES = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         active,
    input  logic [COORD_W-1:0]           col,
    input  logic [COORD_W-1:0]           row,
    input  logic                         frame_tick,
    input  logic [COORD_W-1:0]           char_pos_x,
    input  logic [COORD_W-1:0]           char_pos_y,
    input  logic                         bomb_drop,
    input  logic                         cfg_we,
    input  logic [$clog2(NUM_WALLS)-1:0] cfg_idx,
    input  logic [COORD_W-1:0]           cfg_l,
    input  logic [COORD_W-1:0]           cfg_r,
    input  logic [COORD_W-1:0]           cfg_u,
    input  logic [COORD_W-1:0]           cfg_d,
    input  logic                         cfg_brk,
    output logic [7:0]                   VGA_R,
    output logic [7:0]                   VGA_G,
    output logic [7:0]                   VGA_B,
    output logic                         coll,
    output logic                         coll_miner,
    output logic                         death,
    output logic                         bomb_active,
    output logic [NUM_WALLS-1:0]         walls_alive
);

    localparam int IDX_W  = $clog2(NUM_WALLS);
    localparam int EW     = COORD_W + 2;
    localparam int FUSE_W = $clog2(FUSE_FRAMES + 1);

    typedef logic [EW-1:0] ext_t;
    typedef enum logic [1:0] {BOMB_IDLE, BOMB_LIT, BOMB_BLAST} bomb_state_t;

    localparam ext_t HX_E      = ext_t'(CHAR_HX);
    localparam ext_t HY_E      = ext_t'(CHAR_HY);
    localparam ext_t H_RES_E   = ext_t'(H_RES);
    localparam ext_t V_RES_E   = ext_t'(V_RES);
    localparam ext_t EN_X_E    = ext_t'(EN_X);
    localparam ext_t EN_HX_E   = ext_t'(EN_HX);
    localparam ext_t EN_HY_E   = ext_t'(EN_HY);
    localparam ext_t MIN_X_E   = ext_t'(MIN_X);
    localparam ext_t MIN_Y_E   = ext_t'(MIN_Y);
    localparam ext_t MIN_HX_E  = ext_t'(MIN_HX);
    localparam ext_t MIN_HY_E  = ext_t'(MIN_HY);
    localparam ext_t BOMB_H_E  = ext_t'(BOMB_H);
    localparam ext_t BLAST_R_E = ext_t'(BLAST_R);
    localparam logic [COORD_W-1:0] Y_MIN = COORD_W'(EN_Y_MIN);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(EN_Y_MAX);
    localparam logic [COORD_W-1:0] Y_STEP = COORD_W'(EN_STEP);

    function automatic ext_t ext(input logic [COORD_W-1:0] v);
        return {{(EW-COORD_W){1'b0}}, v};
    endfunction

    // Inclusive overlap of the span c±h with [lo,hi], written with additions only
    // so nothing wraps below zero.
    function automatic logic span_hit(input ext_t c, input ext_t h, input ext_t lo, input ext_t hi);
        return (c + h >= lo) && (hi + h >= c);
    endfunction

    function automatic logic strict_in(input ext_t p, input ext_t c, input ext_t h);
        return (p + h > c) && (p < c + h);
    endfunction

    logic [COORD_W-1:0] wall_l [NUM_WALLS];
    logic [COORD_W-1:0] wall_r [NUM_WALLS];
    logic [COORD_W-1:0] wall_u [NUM_WALLS];
    logic [COORD_W-1:0] wall_d [NUM_WALLS];
    logic [NUM_WALLS-1:0] wall_brk, wall_valid, wall_live;

    bomb_state_t         bomb_state;
    logic [FUSE_W-1:0]   fuse;
    logic [COORD_W-1:0]  bomb_x, bomb_y;
    logic [COORD_W-1:0]  spider_y, spider_y_next;
    logic                spider_down, spider_down_next, spider_alive;

    ext_t hx, hy, bx, by, sy, px, py;
    logic edge_hit, spider_touch, miner_touch, blast_hero, blast_spider;
    logic [NUM_WALLS-1:0] wall_hit, blast_clear;
    logic pix_hero, pix_spider, pix_miner, pix_bomb, pix_wall_u, pix_wall_b;

    logic s1_hero, s1_spider, s1_miner, s1_bomb, s1_wall_u, s1_wall_b, s1_show;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        hx           = ext(char_pos_x);
        hy           = ext(char_pos_y);
        bx           = ext(bomb_x);
        by           = ext(bomb_y);
        sy           = ext(spider_y);
        px           = ext(col);
        py           = ext(row);
        wall_hit     = '0;
        blast_clear  = '0;
        pix_wall_u   = 1'b0;
        pix_wall_b   = 1'b0;

        edge_hit = (hx <= HX_E) || (hx + HX_E >= H_RES_E) ||
                   (hy <= HY_E) || (hy + HY_E >= V_RES_E);

        for (int i = 0; i < NUM_WALLS; i++) begin
            wall_hit[i] = wall_valid[i] && wall_live[i] &&
                          span_hit(hx, HX_E, ext(wall_l[i]), ext(wall_r[i])) &&
                          span_hit(hy, HY_E, ext(wall_u[i]), ext(wall_d[i]));
            blast_clear[i] = wall_valid[i] && wall_brk[i] &&
                             span_hit(bx, BLAST_R_E, ext(wall_l[i]), ext(wall_r[i])) &&
                             span_hit(by, BLAST_R_E, ext(wall_u[i]), ext(wall_d[i]));
            if (wall_valid[i] && wall_live[i] &&
                col > wall_l[i] && col < wall_r[i] && row > wall_u[i] && row < wall_d[i]) begin
                if (wall_brk[i]) pix_wall_b = 1'b1;
                else             pix_wall_u = 1'b1;
            end
        end

        spider_touch = span_hit(hx, HX_E + EN_HX_E, EN_X_E, EN_X_E) &&
                       span_hit(hy, HY_E + EN_HY_E, sy, sy);
        miner_touch  = span_hit(hx, HX_E + MIN_HX_E, MIN_X_E, MIN_X_E) &&
                       span_hit(hy, HY_E + MIN_HY_E, MIN_Y_E, MIN_Y_E);
        blast_hero   = span_hit(hx, HX_E + BLAST_R_E, bx, bx) &&
                       span_hit(hy, HY_E + BLAST_R_E, by, by);
        blast_spider = span_hit(EN_X_E, EN_HX_E + BLAST_R_E, bx, bx) &&
                       span_hit(sy, EN_HY_E + BLAST_R_E, by, by);

        pix_hero   = strict_in(px, hx, HX_E) && strict_in(py, hy, HY_E);
        pix_spider = spider_alive && strict_in(px, EN_X_E, EN_HX_E) && strict_in(py, sy, EN_HY_E);
        pix_miner  = !coll_miner && strict_in(px, MIN_X_E, MIN_HX_E) && strict_in(py, MIN_Y_E, MIN_HY_E);
        pix_bomb   = (bomb_state == BOMB_LIT) && strict_in(px, bx, BOMB_H_E) && strict_in(py, by, BOMB_H_E);
    end

    // Spider bounce: saturate at the bound and turn round on that same tick.
    always_comb begin
        spider_y_next    = spider_y;
        spider_down_next = spider_down;
        if (spider_down) begin
            if (spider_y + Y_STEP >= Y_MAX) begin
                spider_y_next    = Y_MAX;
                spider_down_next = 1'b0;
            end else begin
                spider_y_next = spider_y + Y_STEP;
            end
        end else begin
            if (spider_y <= Y_MIN + Y_STEP) begin
                spider_y_next    = Y_MIN;
                spider_down_next = 1'b1;
            end else begin
                spider_y_next = spider_y - Y_STEP;
            end
        end
    end

    // NOTE: wall coordinates are plain storage with no reset; wall_valid gates every use.
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            wall_l[cfg_idx] <= cfg_l;
            wall_r[cfg_idx] <= cfg_r;
            wall_u[cfg_idx] <= cfg_u;
            wall_d[cfg_idx] <= cfg_d;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wall_brk     <= '0;
            wall_valid   <= '0;
            wall_live    <= '0;
            walls_alive  <= '0;
            coll         <= 1'b0;
            coll_miner   <= 1'b0;
            death        <= 1'b0;
            spider_y     <= Y_MIN;
            spider_down  <= 1'b1;
            spider_alive <= 1'b1;
            bomb_state   <= BOMB_IDLE;
            bomb_active  <= 1'b0;
            fuse         <= '0;
            bomb_x       <= '0;
            bomb_y       <= '0;
        end else begin
            coll        <= enable && (edge_hit || (|wall_hit));
            walls_alive <= wall_valid & wall_live;

            if (enable && miner_touch)
                coll_miner <= 1'b1;
            if ((enable && spider_alive && spider_touch) ||
                (bomb_state == BOMB_BLAST && blast_hero))
                death <= 1'b1;

            if (enable && frame_tick && spider_alive) begin
                spider_y    <= spider_y_next;
                spider_down <= spider_down_next;
            end
            if (bomb_state == BOMB_BLAST && blast_spider)
                spider_alive <= 1'b0;

            // A table write on the blast cycle takes priority over the clear.
            for (int i = 0; i < NUM_WALLS; i++) begin
                if (cfg_we && cfg_idx == IDX_W'(i)) begin
                    wall_brk[i]   <= cfg_brk;
                    wall_valid[i] <= 1'b1;
                    wall_live[i]  <= 1'b1;
                end else if (bomb_state == BOMB_BLAST && blast_clear[i]) begin
                    wall_live[i] <= 1'b0;
                end
            end

            case (bomb_state)
                BOMB_IDLE: begin
                    if (enable && bomb_drop) begin
                        bomb_x      <= char_pos_x;
                        bomb_y      <= char_pos_y;
                        fuse        <= FUSE_W'(FUSE_FRAMES);
                        bomb_state  <= BOMB_LIT;
                        bomb_active <= 1'b1;
                    end
                end
                BOMB_LIT: begin
                    if (enable && frame_tick) begin
                        if (fuse == FUSE_W'(1)) bomb_state <= BOMB_BLAST;
                        else                    fuse <= fuse - FUSE_W'(1);
                    end
                end
                BOMB_BLAST: begin
                    bomb_state  <= BOMB_IDLE;
                    bomb_active <= 1'b0;
                end
                default: begin
                    bomb_state  <= BOMB_IDLE;
                    bomb_active <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_hero   <= 1'b0;
            s1_spider <= 1'b0;
            s1_miner  <= 1'b0;
            s1_bomb   <= 1'b0;
            s1_wall_u <= 1'b0;
            s1_wall_b <= 1'b0;
            s1_show   <= 1'b0;
            VGA_R     <= 8'h00;
            VGA_G     <= 8'h00;
            VGA_B     <= 8'h00;
        end else begin
            s1_hero   <= pix_hero;
            s1_spider <= pix_spider;
            s1_miner  <= pix_miner;
            s1_bomb   <= pix_bomb;
            s1_wall_u <= pix_wall_u;
            s1_wall_b <= pix_wall_b;
            s1_show   <= active && enable;
            if (s1_show) begin
                VGA_R <= (s1_hero ? 8'hC8 : 8'h00) | (s1_spider ? 8'hC8 : 8'h00) |
                         (s1_wall_u ? 8'hFF : 8'h00);
                VGA_G <= s1_miner ? 8'hC8 : 8'h00;
                VGA_B <= (s1_wall_b || s1_bomb) ? 8'hFF : 8'h00;
            end else begin
                VGA_R <= 8'h00;
                VGA_G <= 8'h00;
                VGA_B <= 8'h00;
            end
        end
    end

endmodule
